// File: rtl/cajipci_pkg.sv
// Shared constants and types for the CDCE62005 configuration sequencer.
package cajipci_pkg;

  // Low nibble that turns an SPI word into a CDCE62005 register read command
  localparam logic [3:0] CDCE_RD_CMD = 4'hE;

  // Chip-select codes understood by SPI_Master
  localparam logic [1:0] SPI_SEL_NONE = 2'd0;
  localparam logic [1:0] SPI_SEL_CDCE = 2'd1;
  localparam logic [1:0] SPI_SEL_ADC  = 2'd2;
  localparam logic [1:0] SPI_SEL_AUX  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ISSUE = 4'd1,
    ST_WR_WAIT  = 4'd2,
    ST_GAP      = 4'd3,
    ST_RD_ISSUE = 4'd4,
    ST_RD_WAIT  = 4'd5,
    ST_DM_ISSUE = 4'd6,
    ST_DM_WAIT  = 4'd7,
    ST_CMP      = 4'd8,
    ST_NEXT     = 4'd9,
    ST_FINISH   = 4'd10
  } seq_state_e;

  // Read command word for a given CDCE register address
  function automatic logic [31:0] cdce_rd_word(input logic [3:0] reg_addr);
    return {24'h00_0000, reg_addr, CDCE_RD_CMD};
  endfunction

endpackage

// File: rtl/cdce_cfg_sequencer_tbl_ram.sv
// Register table: DEPTH x 32 distributed RAM, one write port, one registered
// read port. A write to the address being read is forwarded so that a table
// write in the same cycle as GO is seen by the first issue.
module cfg_tbl_ram #(
  parameter int DEPTH = 9,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Table storage write and write-forwarding registered read
  always_ff @(posedge i_clk) begin
    if (i_we && (int'(i_waddr) < DEPTH)) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_we && (i_waddr == i_raddr)) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cdce_cfg_sequencer.sv
// Walks the register table and drives SPI_Master to program a CDCE62005,
// optionally reading every entry back and flagging the first mismatch or
// SPI timeout.
module cdce_cfg_sequencer
  import cajipci_pkg::*;
#(
  parameter int          DEPTH      = 9,
  parameter bit          VERIFY     = 1'b1,
  parameter int          GAP_CYC    = 8,
  parameter logic [15:0] TIMEOUT    = 16'hFFFF,
  parameter logic [31:0] READ_DUMMY = 32'h0000_000E,
  localparam int         AW         = $clog2(DEPTH)
) (
  input  logic          i_board_clock,
  input  logic          i_rst_n,
  input  logic          i_tbl_we,
  input  logic [AW-1:0] i_tbl_addr,
  input  logic [31:0]   i_tbl_data,
  input  logic [1:0]    i_cfg_sel,
  input  logic          i_go,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [AW-1:0] o_err_idx,
  output logic          o_err_to,
  output logic [31:0]   o_spi,
  output logic [1:0]    o_spi_sel,
  output logic          o_spi_star,
  input  logic          i_spi_done,
  input  logic [31:0]   i_spi
);

  seq_state_e    r_state;
  seq_state_e    r_gap_ret;
  logic [AW-1:0] r_idx;
  logic [15:0]   r_wait;
  logic [15:0]   r_gap;
  logic [27:0]   r_rdback;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          r_err_to;
  logic [AW-1:0] r_err_idx;
  logic [31:0]   r_spi;
  logic [1:0]    r_sel;
  logic          r_star;

  logic          w_tbl_we;
  logic [31:0]   w_tbl_q;
  logic          w_unused;

  // The table is frozen while a sequence runs
  assign w_tbl_we = i_tbl_we & (r_state == ST_IDLE);
  // Address nibble of the readback word is never compared
  assign w_unused = ^i_spi[3:0];

  cfg_tbl_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_tbl (
    .i_clk   (i_board_clock),
    .i_we    (w_tbl_we),
    .i_waddr (i_tbl_addr),
    .i_wdata (i_tbl_data),
    .i_raddr (r_idx),
    .o_rdata (w_tbl_q)
  );

  // Sequencer FSM with gap/timeout counters, error capture and registered outputs
  always_ff @(posedge i_board_clock) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_gap_ret <= ST_IDLE;
      r_idx     <= '0;
      r_wait    <= 16'd0;
      r_gap     <= 16'd0;
      r_rdback  <= 28'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_to  <= 1'b0;
      r_err_idx <= '0;
      r_spi     <= 32'd0;
      r_sel     <= 2'd0;
      r_star    <= 1'b0;
    end else begin
      r_star <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_go) begin
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
            r_err_to  <= 1'b0;
            r_err_idx <= '0;
            r_sel     <= i_cfg_sel;
            r_state   <= ST_WR_ISSUE;
          end
        end
        ST_WR_ISSUE: begin
          r_spi   <= w_tbl_q;
          r_star  <= 1'b1;
          r_wait  <= 16'd0;
          r_state <= ST_WR_WAIT;
        end
        ST_RD_ISSUE: begin
          r_spi   <= cdce_rd_word(w_tbl_q[3:0]);
          r_star  <= 1'b1;
          r_wait  <= 16'd0;
          r_state <= ST_RD_WAIT;
        end
        ST_DM_ISSUE: begin
          r_spi   <= READ_DUMMY;
          r_star  <= 1'b1;
          r_wait  <= 16'd0;
          r_state <= ST_DM_WAIT;
        end
        ST_WR_WAIT, ST_RD_WAIT, ST_DM_WAIT: begin
          // A completion in the timeout cycle wins over the timeout
          if (i_spi_done) begin
            case (r_state)
              ST_WR_WAIT: begin
                if (VERIFY) begin
                  r_gap     <= 16'd0;
                  r_gap_ret <= ST_RD_ISSUE;
                  r_state   <= ST_GAP;
                end else begin
                  r_state <= ST_NEXT;
                end
              end
              ST_RD_WAIT: begin
                r_gap     <= 16'd0;
                r_gap_ret <= ST_DM_ISSUE;
                r_state   <= ST_GAP;
              end
              default: begin
                r_rdback <= i_spi[31:4];
                r_state  <= ST_CMP;
              end
            endcase
          end else if (r_wait == (TIMEOUT - 16'd1)) begin
            if (!r_err) begin
              r_err     <= 1'b1;
              r_err_to  <= 1'b1;
              r_err_idx <= r_idx;
            end
            r_state <= ST_FINISH;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end
        ST_GAP: begin
          if (r_gap == 16'(GAP_CYC - 1)) begin
            r_state <= r_gap_ret;
          end else begin
            r_gap <= r_gap + 16'd1;
          end
        end
        ST_CMP: begin
          if ((r_rdback != w_tbl_q[31:4]) && !r_err) begin
            r_err     <= 1'b1;
            r_err_to  <= 1'b0;
            r_err_idx <= r_idx;
          end
          r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (r_idx == AW'(DEPTH - 1)) begin
            r_state <= ST_FINISH;
          end else begin
            r_idx     <= r_idx + AW'(1);
            r_gap     <= 16'd0;
            r_gap_ret <= ST_WR_ISSUE;
            r_state   <= ST_GAP;
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_idx   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_idx   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_err_idx  = r_err_idx;
  assign o_err_to   = r_err_to;
  assign o_spi      = r_spi;
  assign o_spi_sel  = r_sel;
  assign o_spi_star = r_star;

endmodule
